pwm_multi_channel: RTL

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_channel.sv | 164 ++++++++++++++++
 rtl/pwm_multi_channel.sv | 43 ++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM types: counting mode and counter direction.
package pwm_pkg;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel with shadow-to-active parameter loading at period boundaries.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int Resolution     = 16,
    parameter int StepResolution = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      mode_i,
    input  logic                      polarity_i,
    input  logic [Resolution-1:0]     threshold_i,
    input  logic [Resolution-1:0]     period_i,
    input  logic [StepResolution-1:0] step_i,
    input  logic                      update_i,
    output logic                      pwm_o,
    output logic                      period_end_o,
    output logic                      update_pending_o
);

    logic [Resolution-1:0]     act_threshold;
    logic [Resolution-1:0]     act_period;
    logic [StepResolution-1:0] act_step;
    mode_e                     act_mode;
    logic                      act_polarity;
    logic                      loaded;

    logic [Resolution-1:0]     counter;
    dir_e                      dir;
    logic                      pending;
    logic                      pwm_q;
    logic                      period_end_q;

    logic [Resolution-1:0]     eff_threshold;
    logic [Resolution-1:0]     eff_period;
    logic [StepResolution-1:0] eff_step;
    mode_e                     eff_mode;
    logic                      eff_polarity;

    logic [Resolution:0]       step_ext;
    logic [Resolution:0]       period_ext;
    logic [Resolution:0]       sum;
    logic [Resolution-1:0]     next_counter;
    dir_e                      next_dir;
    logic                      wrap;
    logic                      idle;
    logic                      active;
    logic                      load_now;

    // Until the first load after reset the inputs stand in for the zeroed active copies,
    // so an enabled channel advances on its very first edge.
    always_comb begin
        eff_threshold = loaded ? act_threshold : threshold_i;
        eff_period    = loaded ? act_period    : period_i;
        eff_step      = loaded ? act_step      : step_i;
        eff_mode      = loaded ? act_mode      : mode_e'(mode_i);
        eff_polarity  = loaded ? act_polarity  : polarity_i;
    end

    assign step_ext   = (Resolution+1)'(eff_step);
    assign period_ext = {1'b0, eff_period};
    assign idle       = (eff_period == '0) || (eff_step == '0) || (step_ext >= period_ext);
    assign active     = (counter < eff_threshold);

    // Sum is one bit wider than the counter so the compare never wraps.
    always_comb begin
        sum          = {1'b0, counter} + step_ext;
        next_counter = counter;
        next_dir     = dir;
        wrap         = 1'b0;
        if (eff_mode == EDGE) begin
            if (sum >= period_ext) begin
                next_counter = '0;
                wrap         = 1'b1;
            end else begin
                next_counter = sum[Resolution-1:0];
            end
        end else if (dir == UP) begin
            if (sum < period_ext) begin
                next_counter = sum[Resolution-1:0];
            end else begin
                next_dir     = DOWN;
                next_counter = ({1'b0, counter} >= step_ext) ? counter - step_ext[Resolution-1:0] : '0;
            end
        end else begin
            if ({1'b0, counter} > step_ext) begin
                next_counter = counter - step_ext[Resolution-1:0];
            end else begin
                next_counter = '0;
                next_dir     = UP;
                wrap         = 1'b1;
            end
        end
    end

    always_comb begin
        load_now = 1'b0;
        if (!enable_i || !loaded) begin
            load_now = 1'b1;
        end else if ((pending || update_i) && (idle || wrap)) begin
            load_now = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_threshold <= '0;
            act_period    <= '0;
            act_step      <= '0;
            act_mode      <= EDGE;
            act_polarity  <= 1'b0;
            loaded        <= 1'b0;
        end else if (load_now) begin
            act_threshold <= threshold_i;
            act_period    <= period_i;
            act_step      <= step_i;
            act_mode      <= mode_e'(mode_i);
            act_polarity  <= polarity_i;
            loaded        <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter      <= '0;
            dir          <= UP;
            pending      <= 1'b0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else if (!enable_i) begin
            counter      <= '0;
            dir          <= UP;
            pending      <= 1'b0;
            pwm_q        <= polarity_i;
            period_end_q <= 1'b0;
        end else if (idle) begin
            counter      <= '0;
            dir          <= UP;
            pending      <= 1'b0;
            pwm_q        <= eff_polarity;
            period_end_q <= 1'b0;
        end else begin
            pwm_q        <= active ^ eff_polarity;
            period_end_q <= wrap;
            if (wrap) begin
                counter <= '0;
                dir     <= UP;
                pending <= 1'b0;
            end else begin
                counter <= next_counter;
                dir     <= next_dir;
                if (update_i) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    assign pwm_o            = pwm_q;
    assign period_end_o     = period_end_q;
    assign update_pending_o = pending;

endmodule

// File: rtl/pwm_multi_channel.sv
// Array of independent PWM channels, one pwm_channel instance per channel.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int Channels       = 4,
    parameter int Resolution     = 16,
    parameter int StepResolution = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [Channels-1:0]                      enable_i,
    input  logic [Channels-1:0]                      mode_i,
    input  logic [Channels-1:0]                      polarity_i,
    input  logic [Channels-1:0][Resolution-1:0]      threshold_i,
    input  logic [Channels-1:0][Resolution-1:0]      period_i,
    input  logic [Channels-1:0][StepResolution-1:0]  step_i,
    input  logic [Channels-1:0]                      update_i,
    output logic [Channels-1:0]                      pwm_o,
    output logic [Channels-1:0]                      period_end_o,
    output logic [Channels-1:0]                      update_pending_o
);

    for (genvar g = 0; g < Channels; g++) begin : g_channel
        pwm_channel #(
            .Resolution     (Resolution),
            .StepResolution (StepResolution)
        ) u_channel (
            .clk_i            (clk_i),
            .rst_ni           (rst_ni),
            .enable_i         (enable_i[g]),
            .mode_i           (mode_i[g]),
            .polarity_i       (polarity_i[g]),
            .threshold_i      (threshold_i[g]),
            .period_i         (period_i[g]),
            .step_i           (step_i[g]),
            .update_i         (update_i[g]),
            .pwm_o            (pwm_o[g]),
            .period_end_o     (period_end_o[g]),
            .update_pending_o (update_pending_o[g])
        );
    end

endmodule
